// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller driving the pad ring control signals.
// Pad inputs are synchronised, edge-detected and latched into sticky IRQ flags.
module gpio_ctrl #(
    parameter int NUMPADS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         bus_addr,
    input  logic               bus_wr,
    input  logic               bus_rd,
    input  logic [7:0]         bus_wdata,
    output logic [7:0]         bus_rdata,
    output logic               irq,
    input  logic [1:NUMPADS]   input_val,
    output logic [1:NUMPADS]   output_val,
    output logic [1:NUMPADS]   output_en,
    output logic [1:NUMPADS]   pullup_en,
    output logic [1:NUMPADS]   pulldown_en,
    output logic [1:NUMPADS]   slew_limit_en,
    output logic [1:NUMPADS]   input_en
);

    localparam logic [7:0] MASK = 8'((16'd1 << NUMPADS) - 16'd1);

    localparam logic [3:0] A_OUT     = 4'h0;
    localparam logic [3:0] A_OE      = 4'h1;
    localparam logic [3:0] A_PU      = 4'h2;
    localparam logic [3:0] A_PD      = 4'h3;
    localparam logic [3:0] A_SLEW    = 4'h4;
    localparam logic [3:0] A_IE      = 4'h5;
    localparam logic [3:0] A_IN      = 4'h6;
    localparam logic [3:0] A_RISE_EN = 4'h7;
    localparam logic [3:0] A_FALL_EN = 4'h8;
    localparam logic [3:0] A_FLAG    = 4'h9;
    localparam logic [3:0] A_SET     = 4'hA;
    localparam logic [3:0] A_CLR     = 4'hB;
    localparam logic [3:0] A_TGL     = 4'hC;

    logic [7:0] out_q, out_d;
    logic [7:0] oe_q, oe_d;
    logic [7:0] pu_q, pu_d;
    logic [7:0] pd_q, pd_d;
    logic [7:0] slew_q, slew_d;
    logic [7:0] ie_q, ie_d;
    logic [7:0] rise_en_q, rise_en_d;
    logic [7:0] fall_en_q, fall_en_d;
    logic [7:0] flag_q, flag_d;
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] s3_q, s3_d;
    logic [7:0] rdata_q, rdata_d;

    logic [7:0] pad_in;
    logic [7:0] wdata_m;
    logic [7:0] flag_clr;
    logic [7:0] flag_set;
    logic [7:0] rd_mux;

    // Pad k lives at register bit k-1.
    always_comb begin
        pad_in = '0;
        for (int k = 1; k <= NUMPADS; k++) begin
            pad_in[k-1] = input_val[k];
        end
    end

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        pu_d      = pu_q;
        pd_d      = pd_q;
        slew_d    = slew_q;
        ie_d      = ie_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        flag_clr  = '0;
        wdata_m   = bus_wdata & MASK;

        if (bus_wr) begin
            case (bus_addr)
                A_OUT:     out_d     = wdata_m;
                A_OE:      oe_d      = wdata_m;
                A_PU:      pu_d      = wdata_m;
                A_PD:      pd_d      = wdata_m;
                A_SLEW:    slew_d    = wdata_m;
                A_IE:      ie_d      = wdata_m;
                A_RISE_EN: rise_en_d = wdata_m;
                A_FALL_EN: fall_en_d = wdata_m;
                A_FLAG:    flag_clr  = wdata_m;
                A_SET:     out_d     = out_q | wdata_m;
                A_CLR:     out_d     = out_q & ~wdata_m;
                A_TGL:     out_d     = out_q ^ wdata_m;
                default:   ;
            endcase
        end

        // A disabled input buffer flushes its synchroniser to 0.
        s1_d = pad_in & ie_q & MASK;
        s2_d = s1_q;
        s3_d = s2_q;

        flag_set = ((s2_q & ~s3_q) & rise_en_q) | ((~s2_q & s3_q) & fall_en_q);
        // A new event outranks a simultaneous write-1-to-clear.
        flag_d   = ((flag_q & ~flag_clr) | flag_set) & MASK;

        case (bus_addr)
            A_OUT:     rd_mux = out_q;
            A_OE:      rd_mux = oe_q;
            A_PU:      rd_mux = pu_q;
            A_PD:      rd_mux = pd_q;
            A_SLEW:    rd_mux = slew_q;
            A_IE:      rd_mux = ie_q;
            A_IN:      rd_mux = s2_q;
            A_RISE_EN: rd_mux = rise_en_q;
            A_FALL_EN: rd_mux = fall_en_q;
            A_FLAG:    rd_mux = flag_q;
            default:   rd_mux = 8'h00;
        endcase

        rdata_d = rdata_q;
        if (bus_rd && !bus_wr) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            pu_q      <= '0;
            pd_q      <= '0;
            slew_q    <= '0;
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            flag_q    <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            pu_q      <= pu_d;
            pd_q      <= pd_d;
            slew_q    <= slew_d;
            ie_q      <= ie_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            flag_q    <= flag_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            rdata_q   <= rdata_d;
        end
    end

    for (genvar k = 1; k <= NUMPADS; k++) begin : g_pad
        assign output_val[k]    = out_q[k-1];
        assign output_en[k]     = oe_q[k-1];
        assign pullup_en[k]     = pu_q[k-1];
        assign pulldown_en[k]   = pd_q[k-1] & ~pu_q[k-1];
        assign slew_limit_en[k] = slew_q[k-1];
        assign input_en[k]      = ie_q[k-1];
    end

    assign irq       = |flag_q;
    assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: an 8-pad and a 4-pad instance share
// clock, reset, address and write data; each has its own bus strobes.
module tb_gpio_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       wr8, rd8, wr4, rd4;
    logic [7:0] r8, r4;
    logic       irq8, irq4;

    logic [1:8] in8, ov8, oe8, pu8, pd8, sl8, ie8;
    logic [1:4] in4, ov4, oe4, pu4, pd4, sl4, ie4;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    gpio_ctrl #(.NUMPADS(8)) u_dut8 (
        .clk(clk), .rst(rst), .bus_addr(addr), .bus_wr(wr8), .bus_rd(rd8),
        .bus_wdata(wdata), .bus_rdata(r8), .irq(irq8), .input_val(in8),
        .output_val(ov8), .output_en(oe8), .pullup_en(pu8), .pulldown_en(pd8),
        .slew_limit_en(sl8), .input_en(ie8)
    );

    gpio_ctrl #(.NUMPADS(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus_addr(addr), .bus_wr(wr4), .bus_rd(rd4),
        .bus_wdata(wdata), .bus_rdata(r4), .irq(irq4), .input_val(in4),
        .output_val(ov4), .output_en(oe4), .pullup_en(pu4), .pulldown_en(pd4),
        .slew_limit_en(sl4), .input_en(ie4)
    );

    // Pad vectors are [1:N]; pad k corresponds to register bit k-1.
    function automatic logic [7:0] p8(input logic [1:8] v);
        logic [7:0] r;
        r = '0;
        for (int k = 1; k <= 8; k++) r[k-1] = v[k];
        return r;
    endfunction

    function automatic logic [7:0] p4(input logic [1:4] v);
        logic [7:0] r;
        r = '0;
        for (int k = 1; k <= 4; k++) r[k-1] = v[k];
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input bit d4, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        if (d4) wr4 = 1'b1; else wr8 = 1'b1;
        @(negedge clk);
        wr8 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic bus_read(input bit d4, input logic [3:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        @(negedge clk);
        addr = a;
        if (d4) rd4 = 1'b1; else rd8 = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        rd8 = 1'b0;
        rd4 = 1'b0;
        e = exp_q.pop_front();
        check(tag, d4 ? r4 : r8, e);
    endtask

    task automatic check_all_zero8(input string tag);
        check({tag, "_out"},  p8(ov8), 8'h00);
        check({tag, "_oe"},   p8(oe8), 8'h00);
        check({tag, "_pu"},   p8(pu8), 8'h00);
        check({tag, "_pd"},   p8(pd8), 8'h00);
        check({tag, "_slew"}, p8(sl8), 8'h00);
        check({tag, "_ie"},   p8(ie8), 8'h00);
        check({tag, "_irq"},  {7'd0, irq8}, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; addr = '0; wdata = '0;
        wr8 = 1'b0; rd8 = 1'b0; wr4 = 1'b0; rd4 = 1'b0;
        in8 = '0; in4 = '0;

        // Reset with random bus traffic
        repeat (2) begin
            @(negedge clk);
            addr  = 4'($urandom_range(0, 15));
            wdata = 8'($urandom_range(0, 255));
            wr8   = 1'($urandom_range(0, 1));
            rd8   = 1'($urandom_range(0, 1));
            wr4   = 1'($urandom_range(0, 1));
            rd4   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b0; wr8 = 1'b0; rd8 = 1'b0; wr4 = 1'b0; rd4 = 1'b0;
        check_all_zero8("rst");
        check("rst_rdata", r8, 8'h00);
        check("rst_out4", p4(ov4), 8'h00);
        check("rst_irq4", {7'd0, irq4}, 8'h00);
        for (int a = 0; a < 16; a++) bus_read(1'b0, 4'(a), 8'h00, "rst_read");

        // Output set / clear / toggle
        bus_write(1'b0, 4'h0, 8'hA5); check("out_wr",  p8(ov8), 8'hA5);
        bus_write(1'b0, 4'hA, 8'h0F); check("out_set", p8(ov8), 8'hAF);
        bus_write(1'b0, 4'hB, 8'h81); check("out_clr", p8(ov8), 8'h2E);
        bus_write(1'b0, 4'hC, 8'hFF); check("out_tgl", p8(ov8), 8'hD1);
        bus_read(1'b0, 4'h0, 8'hD1, "rd_out");
        bus_read(1'b0, 4'hA, 8'h00, "rd_set_wo");

        // Random register round-trips
        repeat (4) begin
            d = 8'($urandom_range(0, 255));
            bus_write(1'b0, 4'h4, d);
            check("slew_rand", p8(sl8), d);
            bus_read(1'b0, 4'h4, d, "rd_slew_rand");
            d = 8'($urandom_range(0, 255));
            bus_write(1'b0, 4'h1, d);
            check("oe_rand", p8(oe8), d);
            bus_read(1'b0, 4'h1, d, "rd_oe_rand");
        end

        // Pull conflict: pull-up wins
        bus_write(1'b0, 4'h2, 8'h03);
        bus_write(1'b0, 4'h3, 8'h06);
        check("pullup", p8(pu8), 8'h03);
        check("pulldown", p8(pd8), 8'h04);
        bus_read(1'b0, 4'h3, 8'h06, "rd_pd");

        // Rising edge latency on pad 1
        bus_write(1'b0, 4'h5, 8'h01);
        bus_write(1'b0, 4'h7, 8'h01);
        check("ie_out", p8(ie8), 8'h01);
        in8[1] = 1'b1;                 // before edge N
        @(negedge clk);                // after N
        check("lat_irq_n", {7'd0, irq8}, 8'h00);
        addr = 4'h6; rd8 = 1'b1; exp_q.push_back(8'h00);
        @(negedge clk);                // after N+1
        check("lat_in_n1", r8, exp_q.pop_front());
        check("lat_irq_n1", {7'd0, irq8}, 8'h00);
        exp_q.push_back(8'h01);
        @(negedge clk);                // after N+2
        rd8 = 1'b0;
        check("lat_in_n2", r8, exp_q.pop_front());
        check("lat_irq_n2", {7'd0, irq8}, 8'h01);
        bus_read(1'b0, 4'h9, 8'h01, "rd_flag_rise");

        // Clear, then a falling edge with FALL_EN=0 sets nothing
        bus_write(1'b0, 4'h9, 8'h01);
        check("w1c_irq", {7'd0, irq8}, 8'h00);
        in8[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("fall_dis_irq", {7'd0, irq8}, 8'h00);
        bus_read(1'b0, 4'h9, 8'h00, "rd_flag_fall_dis");

        // Get flag to 1, then W1C coinciding with a new rise event
        in8[1] = 1'b1;
        repeat (4) @(negedge clk);
        check("rise2_irq", {7'd0, irq8}, 8'h01);
        in8[1] = 1'b0;
        repeat (4) @(negedge clk);
        in8[1] = 1'b1;                 // before edge N
        @(negedge clk);                // after N
        @(negedge clk);                // after N+1; event live at N+2
        addr = 4'h9; wdata = 8'h01; wr8 = 1'b1;
        @(negedge clk);                // after N+2
        wr8 = 1'b0;
        check("w1c_vs_set_irq", {7'd0, irq8}, 8'h01);
        bus_read(1'b0, 4'h9, 8'h01, "rd_flag_set_wins");
        bus_write(1'b0, 4'h9, 8'h01);
        check("w1c_late_irq", {7'd0, irq8}, 8'h00);
        bus_read(1'b0, 4'h9, 8'h00, "rd_flag_cleared");

        // Falling edge with FALL_EN=1
        bus_write(1'b0, 4'h8, 8'h01);
        in8[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("fall_en_irq", {7'd0, irq8}, 8'h01);
        bus_write(1'b0, 4'h9, 8'hFF);
        check("fall_clr_irq", {7'd0, irq8}, 8'h00);

        // Reset in the middle of a write aborts it
        bus_write(1'b0, 4'h0, 8'h5A);
        check("pre_rst_out", p8(ov8), 8'h5A);
        @(negedge clk);
        addr = 4'h0; wdata = 8'h3C; wr8 = 1'b1; rst = 1'b1;
        @(negedge clk);
        wr8 = 1'b0; rst = 1'b0;
        check_all_zero8("midrst");
        bus_read(1'b0, 4'h0, 8'h00, "rd_out_midrst");

        // Width limit on the 4-pad instance
        bus_write(1'b1, 4'h1, 8'hFF);
        check("w4_oe", p4(oe4), 8'h0F);
        bus_read(1'b1, 4'h1, 8'h0F, "w4_rd_oe");
        bus_read(1'b1, 4'hF, 8'h00, "w4_rd_unmapped");
        bus_write(1'b1, 4'h0, 8'hF0);
        check("w4_out_hi", p4(ov4), 8'h00);
        bus_read(1'b1, 4'h0, 8'h00, "w4_rd_out_hi");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Register-mapped GPIO controller sitting directly upstream of the pad ring. It drives the per-pad control signals of the pads interface (output_val, output_en, pullup_en, pulldown_en, slew_limit_en, input_en) and consumes input_val from the pads. Pad inputs are synchronised and edge-detected into a sticky interrupt flag register that raises a CPU interrupt. Pad k (1-based) maps to register bit k-1.

Parameters:
NUMPADS, 8, number of pads served (1..8); register bits at and above NUMPADS read 0 and ignore writes

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
bus_addr  input  4  register address
bus_wr  input  1  write strobe, one-cycle
bus_rd  input  1  read strobe, one-cycle; bus_wr has priority if both are high
bus_wdata  input  8  write data
bus_rdata  output  8  read data, registered
irq  output  1  interrupt, OR of (IRQ_FLAG)
input_val  input  [1:NUMPADS]  raw asynchronous pad input values
output_val  output  [1:NUMPADS]  pad output drive value
output_en  output  [1:NUMPADS]  pad output enable
pullup_en  output  [1:NUMPADS]  pull-up enable
pulldown_en  output  [1:NUMPADS]  pull-down enable, after conflict resolution
slew_limit_en  output  [1:NUMPADS]  slew limiting enable
input_en  output  [1:NUMPADS]  pad input buffer enable

Behaviour:
- Register map, RW unless noted: 0x0 OUT, 0x1 OE, 0x2 PU, 0x3 PD, 0x4 SLEW, 0x5 IE, 0x6 IN (RO), 0x7 RISE_EN, 0x8 FALL_EN, 0x9 IRQ_FLAG (read; write-1-to-clear), 0xA OUT_SET (WO, OUT |= wdata), 0xB OUT_CLR (WO, OUT &= ~wdata), 0xC OUT_TGL (WO, OUT ^= wdata). Write-only and unmapped addresses read 0x00; writes to RO or unmapped addresses are ignored.
- Writes take effect at the clk edge where bus_wr=1. The pad outputs are direct register outputs and change in the same cycle the register updates.
- Reads: bus_rdata is loaded at the edge where bus_rd=1 and bus_wr=0, so data is valid in the following cycle. bus_rdata holds its value otherwise.
- Pull conflict: pulldown_en[k] = PD[k] & ~PU[k], so pull-up wins. Reading PD returns the stored value, not the resolved one.
- Input path per pad, each stage a flop:
  - s1 <= input_val & IE.
  - s2 <= s1.
  - s3 <= s2.
  - IN reads s2.
  - A rising event is s2 & ~s3; a falling event is ~s2 & s3.
  - Total latency is 3 edges from an input_val change to IRQ_FLAG set and irq high.
  - While IE=0 the chain flushes to 0. Enabling IE with the pad held high produces a rising event; software enables IE before RISE_EN.
- IRQ_FLAG[k] is set when (rise event & RISE_EN[k]) | (fall event & FALL_EN[k]). Flags are sticky. A W1C write clears the selected bits. If a set and a clear of the same bit coincide, set wins.
- irq is combinational OR of IRQ_FLAG[NUMPADS-1:0].
- Reset (rst=1 at an edge): all registers, s1/s2/s3, and bus_rdata go to 0. Therefore:
  - All pad outputs are 0 (outputs disabled, input buffers off, no pulls).
  - irq=0.
- Reset asserted mid-access aborts the access; the write is not applied.

Test Plan:
- Reset: hold rst for 2 cycles with random bus activity -> every output 0, bus_rdata=0x00, irq=0, read of every address returns 0x00.
- Output set/clear/toggle (NUMPADS=8): write OUT=0xA5, OUT_SET=0x0F, OUT_CLR=0x81, OUT_TGL=0xFF -> output_val successive 0xA5, 0xAF, 0x2E, 0xD1; read OUT=0xD1; read 0xA returns 0x00.
- Pull conflict: write PU=0x03, PD=0x06 -> pullup_en=0x03, pulldown_en=0x04; read PD=0x06.
- Rising IRQ latency: IE=0x01, RISE_EN=0x01, drive input_val[1] 0->1 before edge N -> IN bit0=1 after edge N+1, IRQ_FLAG=0x01 and irq=1 after edge N+2; a falling edge with FALL_EN=0 sets no flag.
- W1C vs new event: IRQ_FLAG=0x01, write IRQ_FLAG=0x01 in the cycle a new rise event on pad 1 occurs -> flag remains 1, irq stays 1; a later W1C with no event clears it to 0.
- Width limit (NUMPADS=4): write OE=0xFF -> output_en=0xF, read OE=0x0F; unmapped address 0xF reads 0x00.
